sprite_line_merge: RTL and testbench
====================================

# sprite_line_merge

Parametrised line compositor that merges one background pixel stream with NUM_SPRITES prioritised sprite layers into a ping-pong (A/B) line buffer read by the VGA scan-out. It sits between the background/sprite fetch units and the VGA controller. Beyond the single-sprite merge it adds per-pixel transparency keying, sprite priority, sticky per-sprite collision flags, write-pointer sequencing and overflow detection.

## Interface
- NUM_SPRITES, 4, number of sprite layers; sprite 0 has highest priority (1..8)
- PIXELS, 16, pixels per line buffer bank (≥2); AW = $clog2(PIXELS)
- CW, 8, bits per colour channel
- KEY, {3*CW{1'b0}}, transparent colour {R,G,B}; matching pixels are see-through

- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-low
- readVgaSelector  in  1  0: VGA reads bank A, writes go to B; 1: VGA reads B, writes go to A
- pix_valid  in  1  current bg/sprite inputs form one pixel to write
- R_bg, G_bg, B_bg  in  CW each  background pixel
- R_sp, G_sp, B_sp  in  NUM_SPRITES*CW each  packed sprite pixels, sprite i at [i*CW +: CW]
- sp_active  in  NUM_SPRITES  sprite i covers the current pixel
- rd_addr  in  AW  VGA read address into the display bank
- R_out, G_out, B_out  out  CW each  registered display-bank pixel
- line_done  out  1  one-cycle pulse when the last pixel of a line is written
- overflow  out  1  sticky: pix_valid received while write bank full
- collision  out  NUM_SPRITES  per-sprite collision flags of the previous completed line

## Operation
- Opaque sprite i: sp_active[i]=1 and {R,G,B}_sp[i] != KEY.
- Merged pixel: lowest-index opaque sprite; if none, background (even if it equals KEY).
- Write: on pix_valid and not full, merged pixel stored at wptr of write bank; wptr increments; at wptr = PIXELS-1 the write sets full, pulses line_done next cycle, wptr holds at 0.
- Full: further pix_valid ignored (no write, wptr unchanged), sets overflow; overflow clears only on reset.
- Swap: sel_q registers readVgaSelector; swap = readVgaSelector != sel_q. On swap: wptr restarts at 0 (swap-cycle pixel, if valid, written at address 0, wptr→1), full cleared, collision ← accumulator, accumulator ← swap-cycle flags only.
- Collision accumulation: a valid pixel with ≥2 opaque sprites ORs 1 into the accumulator bit of every opaque sprite in that pixel. Ignored pixels (full) do not accumulate.
- Read: R/G/B_out ← display bank[rd_addr]; rd_addr ≥ PIXELS (non-power-of-two) returns 0.
- Write and read banks never coincide; no read/write hazard.

## Timing
- Reset (async assert, sync release): both banks 0, wptr 0, full 0, sel_q 0, outputs R/G/B_out, line_done, overflow, collision all 0. If readVgaSelector=1 at release, the first edge is a swap (harmless: wptr already 0).
- Write latency: pixel presented at edge n is readable via the other bank after a swap; R/G/B_out valid one cycle after rd_addr.
- line_done high the cycle after the final write, exactly one cycle.
- collision updates on the swap edge, holds for the whole next line.
- Swap coinciding with the final write of a line: swap wins — pixel written at address 0 of the new write bank, no line_done, full stays 0.
- Reset mid-line: all state discarded immediately; buffered pixels lost.

## Configuration
- MERGE_BG_COLLISION_EN defined: an opaque sprite over a background pixel != KEY also sets that sprite's collision bit (sprite-vs-scenery hits). Undefined: only sprite-vs-sprite overlap sets collision; background is never tested and its compare logic is not built.

## Test plan
- Reset with selector 1, then 16 valid pixels bg=20/50/40, no sprites, selector→0, read addr 0..15 -> every R/G/B_out = 20/50/40 one cycle after rd_addr; line_done pulses once after pixel 15.
- Sprite 1=87/32/50 and sprite 2=30/54/41 both active on pixel 3 -> pixel 3 reads 87/32/50; after next swap collision = 4'b0110.
- Sprite 0 active with colour = KEY (00/00/00) over bg 20/50/40 -> pixel reads 20/50/40, collision stays 0 (with MERGE_BG_COLLISION_EN undefined).
- Same sprite 0 with colour 17/17/17 over bg 20/50/40, MERGE_BG_COLLISION_EN defined -> pixel 17/17/17, collision = 4'b0001 after swap; undefined -> 4'b0000.
- 17 valid pixels without swap -> 17th not written, overflow=1 and stays 1 across later swaps until reset.
- Assert reset at pixel 7 of a line -> all outputs 0 immediately; after release, a full line writes from address 0 correctly.

Source files
------------

// File: rtl/sprite_line_merge.sv
// sprite_line_merge: merges a background stream with prioritised sprite layers
// into a ping-pong line buffer. Define MERGE_BG_COLLISION_EN for sprite-vs-scenery hits.
module sprite_line_merge #(
  parameter int NUM_SPRITES = 4,
  parameter int PIXELS = 16,
  parameter int CW = 8,
  parameter logic [3*CW-1:0] KEY = {3*CW{1'b0}},
  localparam int AW = $clog2(PIXELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      readVgaSelector,
  input  logic                      pix_valid,
  input  logic [CW-1:0]             R_bg,
  input  logic [CW-1:0]             G_bg,
  input  logic [CW-1:0]             B_bg,
  input  logic [NUM_SPRITES*CW-1:0] R_sp,
  input  logic [NUM_SPRITES*CW-1:0] G_sp,
  input  logic [NUM_SPRITES*CW-1:0] B_sp,
  input  logic [NUM_SPRITES-1:0]    sp_active,
  input  logic [AW-1:0]             rd_addr,
  output logic [CW-1:0]             R_out,
  output logic [CW-1:0]             G_out,
  output logic [CW-1:0]             B_out,
  output logic                      line_done,
  output logic                      overflow,
  output logic [NUM_SPRITES-1:0]    collision
);

  localparam int PW = 3 * CW;

  logic [PW-1:0]          bank_a [PIXELS];
  logic [PW-1:0]          bank_b [PIXELS];
  logic [AW-1:0]          wptr;
  logic                   full;
  logic                   sel_q;
  logic [NUM_SPRITES-1:0] acc;
  logic [NUM_SPRITES-1:0] opaque;
  logic [NUM_SPRITES-1:0] flags;
  logic                   seen;
  logic                   multi;
  logic [PW-1:0]          merged;
  logic [PW-1:0]          rd_q;
  logic                   swap;
  logic                   wr_en;
  logic                   last;
  logic                   rd_ok;
  logic [AW-1:0]          wr_addr;

  assign swap    = readVgaSelector != sel_q;
  assign wr_en   = pix_valid && (swap || !full);
  assign wr_addr = swap ? '0 : wptr;
  assign last    = wptr == AW'(PIXELS - 1);
  assign rd_ok   = int'(rd_addr) < PIXELS;

  // A sprite is opaque when it covers the pixel and is not the key colour
  always_comb begin
    opaque = '0;
    for (int i = 0; i < NUM_SPRITES; i++)
      opaque[i] = sp_active[i] &&
        ({R_sp[i*CW +: CW], G_sp[i*CW +: CW], B_sp[i*CW +: CW]} != KEY);
  end

  // Lowest-index opaque sprite wins; background otherwise
  always_comb begin
    merged = {R_bg, G_bg, B_bg};
    for (int i = NUM_SPRITES - 1; i >= 0; i--)
      if (opaque[i])
        merged = {R_sp[i*CW +: CW], G_sp[i*CW +: CW], B_sp[i*CW +: CW]};
  end

  // Per-pixel collision flags: every opaque sprite when two or more overlap
  always_comb begin
    seen  = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < NUM_SPRITES; i++)
      if (opaque[i]) begin
        multi = multi | seen;
        seen  = 1'b1;
      end
    flags = multi ? opaque : '0;
`ifdef MERGE_BG_COLLISION_EN
    if ({R_bg, G_bg, B_bg} != KEY)
      flags = opaque;
`endif
  end

  // Write the merged pixel into the bank the VGA side is not reading
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < PIXELS; i++) begin
        bank_a[i] <= '0;
        bank_b[i] <= '0;
      end
    end else if (wr_en) begin
      if (readVgaSelector)
        bank_a[wr_addr] <= merged;
      else
        bank_b[wr_addr] <= merged;
    end
  end

  // Write pointer, full/overflow, line_done and collision sequencing
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_q     <= 1'b0;
      wptr      <= '0;
      full      <= 1'b0;
      acc       <= '0;
      collision <= '0;
      overflow  <= 1'b0;
      line_done <= 1'b0;
    end else begin
      sel_q     <= readVgaSelector;
      line_done <= 1'b0;
      if (swap) begin
        full      <= 1'b0;
        collision <= acc;
        acc       <= wr_en ? flags : '0;
        wptr      <= wr_en ? AW'(1) : '0;
      end else if (pix_valid) begin
        if (full) begin
          overflow <= 1'b1;
        end else begin
          acc <= acc | flags;
          if (last) begin
            full      <= 1'b1;
            wptr      <= '0;
            line_done <= 1'b1;
          end else begin
            wptr <= wptr + AW'(1);
          end
        end
      end
    end
  end

  // Registered read from the display bank; out-of-range addresses give 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      rd_q <= '0;
    else if (!rd_ok)
      rd_q <= '0;
    else if (readVgaSelector)
      rd_q <= bank_b[rd_addr];
    else
      rd_q <= bank_a[rd_addr];
  end

  assign R_out = rd_q[PW-1 -: CW];
  assign G_out = rd_q[2*CW-1 -: CW];
  assign B_out = rd_q[CW-1:0];

endmodule

// File: tb/tb_sprite_line_merge.sv
// tb_sprite_line_merge: directed bench for sprite_line_merge
// (default 4 sprites, 16 pixels, 8-bit channels, key 000000).
module tb_sprite_line_merge;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic        pix_valid;
  logic [7:0]  R_bg, G_bg, B_bg;
  logic [31:0] R_sp, G_sp, B_sp;
  logic [3:0]  sp_active;
  logic [3:0]  rd_addr;
  logic [7:0]  R_out, G_out, B_out;
  logic        line_done;
  logic        overflow;
  logic [3:0]  collision;

  int checks = 0;
  int failures = 0;

  localparam logic [23:0] BG = {8'd20, 8'd50, 8'd40};
  localparam logic [23:0] S1 = {8'd87, 8'd32, 8'd50};
  localparam logic [23:0] S2 = {8'd30, 8'd54, 8'd41};
  localparam logic [23:0] GR = {8'd17, 8'd17, 8'd17};
  localparam logic [23:0] P77 = {8'd77, 8'd7, 8'd7};

`ifdef MERGE_BG_COLLISION_EN
  localparam logic [3:0] COL2 = 4'b0111;
`else
  localparam logic [3:0] COL2 = 4'b0110;
`endif

  sprite_line_merge dut (
    .clk(clk),
    .reset(reset),
    .readVgaSelector(sel),
    .pix_valid(pix_valid),
    .R_bg(R_bg),
    .G_bg(G_bg),
    .B_bg(B_bg),
    .R_sp(R_sp),
    .G_sp(G_sp),
    .B_sp(B_sp),
    .sp_active(sp_active),
    .rd_addr(rd_addr),
    .R_out(R_out),
    .G_out(G_out),
    .B_out(B_out),
    .line_done(line_done),
    .overflow(overflow),
    .collision(collision)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [23:0] bg,
                       input logic [3:0] act,
                       input logic [23:0] c0, input logic [23:0] c1,
                       input logic [23:0] c2, input logic [23:0] c3);
    logic [23:0] c [4];
    c[0] = c0; c[1] = c1; c[2] = c2; c[3] = c3;
    pix_valid = v;
    {R_bg, G_bg, B_bg} = bg;
    sp_active = act;
    for (int i = 0; i < 4; i++) begin
      R_sp[i*8 +: 8] = c[i][23:16];
      G_sp[i*8 +: 8] = c[i][15:8];
      B_sp[i*8 +: 8] = c[i][7:0];
    end
  endtask

  task automatic idle();
    drive(1'b0, 24'h0, 4'h0, 24'h0, 24'h0, 24'h0, 24'h0);
  endtask

  function automatic logic [31:0] rgb();
    return {8'h0, R_out, G_out, B_out};
  endfunction

  function automatic logic [23:0] l3(input int k);
    return {8'(k + 1), 8'(2 * k), 8'(100 + k)};
  endfunction

  function automatic logic [23:0] l4(input int k);
    return {8'(200 + k), 8'd1, 8'd2};
  endfunction

  function automatic logic [23:0] l5(input int k);
    return {8'(50 + k), 8'(k), 8'd9};
  endfunction

  initial begin
    reset = 1'b0;
    sel = 1'b1;
    rd_addr = '0;
    idle();
    tick();
    tick();
    chk("rst_rgb", rgb(), 32'h0);
    chk("rst_line_done", 32'(line_done), 32'h0);
    chk("rst_overflow", 32'(overflow), 32'h0);
    chk("rst_collision", 32'(collision), 32'h0);
    reset = 1'b1;

    // line 1 into bank A (first edge is a swap)
    for (int k = 0; k < 16; k++) begin
      drive(1'b1, BG, 4'h0, 24'h0, 24'h0, 24'h0, 24'h0);
      tick();
      chk($sformatf("l1_line_done%0d", k), 32'(line_done), 32'(k == 15));
    end
    idle();
    sel = 1'b0;
    tick();
    chk("l1_line_done_end", 32'(line_done), 32'h0);
    chk("l1_collision", 32'(collision), 32'h0);

    // read line 1 from A while writing line 2 into B
    for (int k = 0; k < 16; k++) begin
      rd_addr = 4'(k);
      if (k == 3)
        drive(1'b1, BG, 4'b0110, 24'h0, S1, S2, 24'h0);
      else if (k == 5)
        drive(1'b1, BG, 4'b0001, 24'h0, 24'h0, 24'h0, 24'h0);
      else if (k == 7)
        drive(1'b1, BG, 4'b0001, GR, 24'h0, 24'h0, 24'h0);
      else
        drive(1'b1, BG, 4'h0, 24'h0, 24'h0, 24'h0, 24'h0);
      tick();
      chk($sformatf("l1_px%0d", k), rgb(), 32'(BG));
      chk($sformatf("l2_line_done%0d", k), 32'(line_done), 32'(k == 15));
    end
    idle();
    sel = 1'b1;
    tick();
    chk("l2_collision", 32'(collision), 32'(COL2));

    // read line 2 from B while writing 17 pixels of line 3 into A
    for (int k = 0; k < 17; k++) begin
      rd_addr = (k < 16) ? 4'(k) : 4'd0;
      drive(1'b1, l3(k), 4'h0, 24'h0, 24'h0, 24'h0, 24'h0);
      tick();
      if (k < 16)
        chk($sformatf("l2_px%0d", k), rgb(),
            32'((k == 3) ? S1 : (k == 7) ? GR : BG));
      chk($sformatf("l3_line_done%0d", k), 32'(line_done), 32'(k == 15));
      chk($sformatf("l3_overflow%0d", k), 32'(overflow), 32'(k == 16));
    end
    idle();
    sel = 1'b0;
    tick();
    chk("l3_collision", 32'(collision), 32'h0);
    chk("l3_overflow_swap", 32'(overflow), 32'h1);

    // read line 3 from A while writing 15 pixels of line 4 into B
    for (int k = 0; k < 16; k++) begin
      rd_addr = 4'(k);
      if (k < 15)
        drive(1'b1, l4(k), 4'h0, 24'h0, 24'h0, 24'h0, 24'h0);
      else
        idle();
      tick();
      chk($sformatf("l3_px%0d", k), rgb(), 32'(l3(k)));
      chk($sformatf("l4_line_done%0d", k), 32'(line_done), 32'h0);
    end

    // swap on what would be the final write: goes to A[0], no line_done
    drive(1'b1, P77, 4'h0, 24'h0, 24'h0, 24'h0, 24'h0);
    sel = 1'b1;
    tick();
    chk("swap_last_line_done", 32'(line_done), 32'h0);
    idle();
    rd_addr = 4'd14;
    tick();
    chk("l4_px14", rgb(), 32'(l4(14)));
    chk("swap_last_line_done2", 32'(line_done), 32'h0);
    rd_addr = 4'd15;
    tick();
    chk("l4_px15_old", rgb(), 32'(BG));
    chk("overflow_sticky", 32'(overflow), 32'h1);
    sel = 1'b0;
    rd_addr = 4'd0;
    tick();
    chk("swap_px_a0", rgb(), 32'(P77));
    rd_addr = 4'd1;
    tick();
    chk("swap_px_a1", rgb(), 32'(l3(1)));

    // reset in the middle of a line
    rd_addr = 4'd0;
    for (int k = 0; k < 7; k++) begin
      drive(1'b1, l5(k), 4'h0, 24'h0, 24'h0, 24'h0, 24'h0);
      tick();
    end
    chk("pre_reset_rgb", rgb(), 32'(P77));
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_rgb", rgb(), 32'h0);
    chk("mid_rst_overflow", 32'(overflow), 32'h0);
    chk("mid_rst_collision", 32'(collision), 32'h0);
    chk("mid_rst_line_done", 32'(line_done), 32'h0);
    idle();
    tick();
    reset = 1'b1;
    tick();
    chk("post_rst_a0", rgb(), 32'h0);

    // full line after reset into B (selector 0, no swap)
    for (int k = 0; k < 16; k++) begin
      drive(1'b1, l5(k), 4'h0, 24'h0, 24'h0, 24'h0, 24'h0);
      tick();
      chk($sformatf("l5_line_done%0d", k), 32'(line_done), 32'(k == 15));
    end
    idle();
    sel = 1'b1;
    tick();
    for (int k = 0; k < 16; k++) begin
      rd_addr = 4'(k);
      tick();
      chk($sformatf("l5_px%0d", k), rgb(), 32'(l5(k)));
    end
    chk("l5_overflow", 32'(overflow), 32'h0);
    chk("l5_collision", 32'(collision), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
